// File: rtl/wide_addsub_pkg.sv
// Shared types and constants for the multi-word add/subtract sequencer.
package wide_addsub_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Word-index width; at least one bit so WORDS=1 still has a legal counter.
  function automatic int idx_w(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/addsub16_slice.sv
// One 16-bit add/subtract slice: s/co = a + (sub ? ~b : b) + ci.
module addsub16_slice
  import wide_addsub_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              sub,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              co
);

  logic [WORD_W-1:0] b_eff;

  assign b_eff   = sub ? ~b : b;
  assign {co, s} = {1'b0, a} + {1'b0, b_eff} + {{WORD_W{1'b0}}, ci};

endmodule

// File: rtl/wide_addsub_seq.sv
// WORDS x 16-bit add/subtract sequencer: one word per cycle, LSW first,
// carry/borrow chained through a register around a single shared slice.
module wide_addsub_seq
  import wide_addsub_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] op_a,
  input  logic [WORD_W*WORDS-1:0] op_b,
  input  logic                    cin,
  input  logic                    subtract,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] result,
  output logic                    cout,
  output logic                    zero
);

  localparam int W  = WORD_W * WORDS;
  localparam int IW = idx_w(WORDS);

  state_t            state, state_nxt;
  logic [IW-1:0]     idx;
  logic              carry;
  logic              sub_reg;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic [W-1:0]      result_reg;
  logic [WORD_W-1:0] slice_s;
  logic              slice_co;
  logic              last_word;

  addsub16_slice u_slice (
    .a   (a_reg[WORD_W-1:0]),
    .b   (b_reg[WORD_W-1:0]),
    .sub (sub_reg),
    .ci  (carry),
    .s   (slice_s),
    .co  (slice_co)
  );

  assign last_word = (idx == IW'(WORDS - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_word) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift down one word per RUN cycle so the slice always sees
  // the low word; the result word is written at its own index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      sub_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            sub_reg <= subtract;
            carry   <= subtract | cin;
            idx     <= '0;
          end
        end
        RUN: begin
          a_reg <= a_reg >> WORD_W;
          b_reg <= b_reg >> WORD_W;
          carry <= slice_co;
          for (int k = 0; k < WORDS; k++) begin
            if (idx == IW'(k)) result_reg[k*WORD_W +: WORD_W] <= slice_s;
          end
          if (!last_word) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign cout   = carry;
  assign zero   = (result_reg == '0);

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Randomized self-checking bench for wide_addsub_seq (WORDS=4) against a
// plain-arithmetic 64-bit reference model.
module tb_wide_addsub_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         subtract = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  wide_addsub_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .subtract  (subtract),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: full-width arithmetic on the whole operand at once.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic ci, input logic sub);
    logic [W:0] r;
    if (sub) r = {(a >= b), a - b};
    else     r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. hold = cycles of out_ready low after out_valid;
  // disturb = change operands and pulse in_valid while RUN is in progress.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic sub, input int hold, input bit disturb);
    logic [W:0] exp;
    int lat;
    exp = model(a, b, ci, sub);
    lat = 0;
    while (!in_ready && lat < 20) begin tick(); lat++; end
    op_a = a; op_b = b; cin = ci; subtract = sub; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom};
    cin = ~ci; subtract = ~sub;
    lat = 0;
    do begin
      if (disturb && lat == 1) in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, " latency"}, W'(lat), W'(WORDS));
    check({tag, " result"}, result, exp[W-1:0]);
    check({tag, " cout"}, W'(cout), W'(exp[W]));
    check({tag, " zero"}, W'(zero), W'(exp[W-1:0] == '0));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold valid"}, W'(out_valid), W'(1));
      check({tag, " hold ready"}, W'(in_ready), W'(0));
      check({tag, " hold result"}, result, exp[W-1:0]);
      check({tag, " hold cout"}, W'(cout), W'(exp[W]));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " post valid"}, W'(out_valid), W'(0));
    check({tag, " post ready"}, W'(in_ready), W'(1));
  endtask

  initial begin
    logic [W-1:0] a, b;
    int acc_t[$];
    int cyc;

    tick(); tick();
    check("reset in_ready", W'(in_ready), W'(1));
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset result", result, '0);
    check("reset cout", W'(cout), W'(0));
    check("reset zero", W'(zero), W'(1));
    rst = 1'b0;
    tick();

    do_op("ripple", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0, 1'b0);
    do_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0, 1'b0);
    do_op("borrow", 64'h0001_0000_0000_0000, 64'h1, 1'b1, 1'b1, 0, 1'b0);
    do_op("neg", 64'h5, 64'h6, 1'b0, 1'b1, 0, 1'b0);
    do_op("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 0, 1'b0);
    do_op("backpressure", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 10, 1'b0);
    do_op("isolation", 64'h0F0F_1111_2222_3333, 64'h0101_0202_0303_0404, 1'b0, 1'b1, 2, 1'b1);

    // Reset while word 2 is being computed.
    op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'h1; cin = 1'b0; subtract = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst out_valid", W'(out_valid), W'(0));
    check("rst in_ready", W'(in_ready), W'(1));
    check("rst result", result, '0);
    check("rst zero", W'(zero), W'(1));
    check("rst cout", W'(cout), W'(0));
    do_op("after_rst", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b1, 1'b0, 1, 1'b0);

    // Back-to-back issue with in_valid and out_ready held high.
    op_a = 64'h1; op_b = 64'h2; in_valid = 1'b1; out_ready = 1'b1;
    cyc = 0;
    while (acc_t.size() < 3 && cyc < 40) begin
      if (in_valid && in_ready) acc_t.push_back(cyc);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check("issue count", W'(acc_t.size()), W'(3));
    if (acc_t.size() == 3) begin
      check("issue gap 1", W'(acc_t[1] - acc_t[0]), W'(WORDS + 2));
      check("issue gap 2", W'(acc_t[2] - acc_t[1]), W'(WORDS + 2));
    end
    cyc = 0;
    while (!(in_ready && !out_valid) && cyc < 20) begin tick(); cyc++; end
    out_ready = 1'b0;
    check("drain idle", W'(in_ready), W'(1));

    // Random operations, with word patterns biased towards carry chains.
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a[31:0] = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) b = {{(W-16){1'b0}}, 16'($urandom)};
      do_op("random", a, b, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
